// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX writeback stage: load size encodings,
// writeback state enum and register index width.
package dlx_pkg;

  localparam int NREG_W = 5;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } wb_state_t;

endpackage

// File: rtl/dlx_load_align.sv
// Big-endian lane selection and zero/sign extension of a data-memory read word,
// with detection of loads whose address is not naturally aligned.
module dlx_load_align
  import dlx_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  output logic [31:0] value,
  output logic        misaligned
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    // Byte 0 sits in the most significant lane.
    case (addr_lo)
      2'd0:    lane_b = rdata[31:24];
      2'd1:    lane_b = rdata[23:16];
      2'd2:    lane_b = rdata[15:8];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    value      = '0;
    misaligned = 1'b0;
    case (size)
      LS_BYTE: value = sgn ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      LS_HALF: begin
        value      = sgn ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
        misaligned = addr_lo[0];
      end
      LS_WORD: begin
        value      = rdata;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dlx_writeback.sv
// DLX writeback stage: retires ALU results and load responses into the register
// file write port, one write pulse per instruction, and counts retirements.
module dlx_writeback
  import dlx_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NREG_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_load,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [1:0]        in_addr_lo,
  input  logic [DW-1:0]     in_result,
  input  logic              dmem_rvalid,
  input  logic [DW-1:0]     dmem_rdata,
  output logic              WB,
  output logic [NREG_W-1:0] Rd,
  output logic [DW-1:0]     reg_s,
  output logic              misalign,
  output logic [31:0]       retired
);

  wb_state_t         state;
  logic [NREG_W-1:0] ld_rd_p1;
  logic              ld_wen_p1;
  logic [1:0]        ld_size_p1;
  logic              ld_sgn_p1;
  logic [1:0]        ld_addr_p1;
  logic [DW-1:0]     ld_value;
  logic              ld_misaligned;

  dlx_load_align u_align (
    .rdata      (dmem_rdata),
    .size       (ld_size_p1),
    .sgn        (ld_sgn_p1),
    .addr_lo    (ld_addr_p1),
    .value      (ld_value),
    .misaligned (ld_misaligned)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      WB         <= 1'b0;
      Rd         <= '0;
      reg_s      <= '0;
      misalign   <= 1'b0;
      retired    <= '0;
      ld_rd_p1   <= '0;
      ld_wen_p1  <= 1'b0;
      ld_size_p1 <= LS_BYTE;
      ld_sgn_p1  <= 1'b0;
      ld_addr_p1 <= '0;
    end else begin
      WB       <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_load) begin
              ld_rd_p1   <= in_rd;
              ld_wen_p1  <= in_wen;
              ld_size_p1 <= in_size;
              ld_sgn_p1  <= in_signed;
              ld_addr_p1 <= in_addr_lo;
              state      <= LOAD_WAIT;
            end else begin
              // Rd/reg_s only move when a write actually happens.
              if (in_wen && (in_rd != '0)) begin
                WB    <= 1'b1;
                Rd    <= in_rd;
                reg_s <= in_result;
              end
              retired <= retired + 32'd1;
            end
          end
        end
        LOAD_WAIT: begin
          if (dmem_rvalid) begin
            if (ld_misaligned) begin
              misalign <= 1'b1;
            end else if (ld_wen_p1 && (ld_rd_p1 != '0)) begin
              WB    <= 1'b1;
              Rd    <= ld_rd_p1;
              reg_s <= ld_value;
            end
            retired <= retired + 32'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_writeback.sv
// Directed plus randomized bench for dlx_writeback against a shift-and-mask
// reference model of load alignment and a simple retirement counter.
module tb_dlx_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic        in_wen, in_load, in_signed;
  logic [1:0]  in_size, in_addr_lo;
  logic [31:0] in_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        WB, misalign;
  logic [4:0]  Rd;
  logic [31:0] reg_s, retired;

  int unsigned exp_retired;
  int          errors = 0;
  int          checks = 0;

  dlx_writeback dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_wen      (in_wen),
    .in_load     (in_load),
    .in_size     (in_size),
    .in_signed   (in_signed),
    .in_addr_lo  (in_addr_lo),
    .in_result   (in_result),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .WB          (WB),
    .Rd          (Rd),
    .reg_s       (reg_s),
    .misalign    (misalign),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: pick the addressed big-endian lane by shifting, then extend.
  task automatic ref_load(input logic [1:0] size, input logic sgn, input logic [1:0] a,
                          input logic [31:0] rdata, output logic [31:0] val, output logic mis);
    int unsigned raw;
    raw = 0;
    mis = 1'b0;
    if (size == 2'd0) begin
      raw = (rdata >> (8 * (3 - int'(a)))) & 32'hFF;
      if (sgn && raw >= 32'h80) raw = raw - 32'h100;
    end else if (size == 2'd1) begin
      raw = (rdata >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
      if (sgn && raw >= 32'h8000) raw = raw - 32'h10000;
      mis = (a % 2) != 0;
    end else if (size == 2'd2) begin
      raw = rdata;
      mis = a != 0;
    end else begin
      mis = 1'b1;
    end
    val = raw;
  endtask

  task automatic check_out(input string tag, input logic wb, input logic [4:0] rd,
                           input logic [31:0] rs, input logic mis);
    chk({tag, "_wb"}, {31'b0, WB}, {31'b0, wb});
    chk({tag, "_misalign"}, {31'b0, misalign}, {31'b0, mis});
    chk({tag, "_retired"}, retired, exp_retired);
    if (wb) begin
      chk({tag, "_rd"}, {27'b0, Rd}, {27'b0, rd});
      chk({tag, "_regs"}, reg_s, rs);
    end
  endtask

  task automatic alu(input string tag, input logic [4:0] rd, input logic wen, input logic [31:0] res);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_load = 1'b0; in_rd = rd; in_wen = wen; in_result = res;
    in_size = 2'($urandom); in_addr_lo = 2'($urandom); in_signed = 1'($urandom);
    tick();
    in_valid = 1'b0;
    exp_retired++;
    check_out(tag, wen && rd != 0, rd, res, 1'b0);
  endtask

  task automatic idle(input string tag, input logic stray);
    in_valid = 1'b0;
    dmem_rvalid = stray;
    dmem_rdata = $urandom;
    tick();
    dmem_rvalid = 1'b0;
    check_out(tag, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic wen,
                         input logic [1:0] size, input logic sgn, input logic [1:0] a,
                         input logic [31:0] rdata, input int delay);
    logic [31:0] ev;
    logic        em;
    ref_load(size, sgn, a, rdata, ev, em);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_load = 1'b1; in_rd = rd; in_wen = wen; in_size = size;
    in_signed = sgn; in_addr_lo = a; in_result = $urandom;
    tick();
    in_valid = 1'b0; in_rd = 5'($urandom); in_wen = 1'($urandom);
    in_size = 2'($urandom); in_signed = 1'($urandom); in_addr_lo = 2'($urandom);
    chk({tag, "_wait_ready"}, {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < delay - 1; i++) begin
      tick();
      chk({tag, "_wait_ready"}, {31'b0, in_ready}, 32'd0);
      chk({tag, "_wait_wb"}, {31'b0, WB}, 32'd0);
    end
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    exp_retired++;
    check_out(tag, !em && wen && rd != 0, rd, ev, em);
  endtask

  initial begin
    exp_retired = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_load = 1'b0;
    in_size = '0; in_signed = 1'b0; in_addr_lo = '0; in_result = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    check_out("reset", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("reset_rd", {27'b0, Rd}, 32'd0);
    chk("reset_regs", reg_s, 32'd0);
    chk("reset_ready", {31'b0, in_ready}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back ALU stream
    alu("alu_r3", 5'd3, 1'b1, 32'h11);
    alu("alu_r4", 5'd4, 1'b1, 32'h22);
    alu("alu_r5", 5'd5, 1'b1, 32'h33);
    chk("alu_retired3", retired, 32'd3);
    idle("alu_gap", 1'b0);

    do_load("lb_signed", 5'd7, 1'b1, 2'b00, 1'b1, 2'b01, 32'h12F45678, 2);
    chk("lb_signed_val", reg_s, 32'hFFFFFFF4);
    idle("lb_after", 1'b0);
    do_load("lh_unsigned", 5'd8, 1'b1, 2'b01, 1'b0, 2'b10, 32'hAAAA8001, 1);
    chk("lh_unsigned_val", reg_s, 32'h00008001);
    do_load("lh_signed", 5'd9, 1'b1, 2'b01, 1'b1, 2'b10, 32'hAAAA8001, 3);
    chk("lh_signed_val", reg_s, 32'hFFFF8001);
    alu("alu_r0", 5'd0, 1'b1, 32'hDEADBEEF);
    do_load("lw_misaligned", 5'd10, 1'b1, 2'b10, 1'b0, 2'b10, 32'h01234567, 2);
    idle("mis_pulse_end", 1'b0);
    idle("stray_rvalid", 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 1) == 0)
        alu("rnd_alu", rd, 1'($urandom_range(0, 3) != 0), $urandom);
      else
        do_load("rnd_load", rd, 1'($urandom_range(0, 3) != 0), 2'($urandom),
                1'($urandom), 2'($urandom), $urandom, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) idle("rnd_idle", 1'($urandom));
    end

    // Reset while a load is outstanding
    in_valid = 1'b1; in_load = 1'b1; in_rd = 5'd12; in_wen = 1'b1;
    in_size = 2'b10; in_addr_lo = 2'b00; in_signed = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("rst_wait_ready", {31'b0, in_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    exp_retired = 0;
    check_out("rst_async", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rst_async_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    check_out("rst_late_rvalid", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rst_late_ready", {31'b0, in_ready}, 32'd1);
    alu("post_rst_alu", 5'd1, 1'b1, 32'h5A5A5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
